// File: rtl/stream_upsizer.sv
// Valid/ready width upsizer: packs RATIO narrow beats into one wide beat, flushing partials on s_last.
// Define STREAM_UPSIZER_MSB_FIRST_EN to fill lanes from RATIO-1 downward instead of from lane 0 upward.
`timescale 1ns/1ps
module stream_upsizer #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [IN_W*RATIO-1:0] m_data,
  output logic [RATIO-1:0]      m_keep,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int CW = $clog2(RATIO);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lane;

`ifdef STREAM_UPSIZER_MSB_FIRST_EN
  localparam logic [CW-1:0] FIRST = CW'(RATIO - 1);
  assign lane = ~cnt;  // RATIO is a power of 2, so ~cnt == RATIO-1-cnt
`else
  localparam logic [CW-1:0] FIRST = '0;
  assign lane = cnt;
`endif

  // In HOLD the input slot frees up exactly when the wide beat drains.
  assign s_ready = (state == FILL) || m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= FILL;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (s_valid) begin
            m_data[lane*IN_W +: IN_W] <= s_data;
            m_keep[lane]              <= 1'b1;
            if (cnt == CW'(RATIO - 1) || s_last) begin
              state   <= HOLD;
              m_valid <= 1'b1;
              m_last  <= s_last;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            if (s_valid) begin
              // Drain and start the next word in the same cycle; stale lanes are zeroed.
              m_data                     <= '0;
              m_data[FIRST*IN_W +: IN_W] <= s_data;
              m_keep                     <= '0;
              m_keep[FIRST]              <= 1'b1;
              if (s_last) begin
                m_last <= 1'b1;
                cnt    <= '0;
              end else begin
                state   <= FILL;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                cnt     <= CW'(1);
              end
            end else begin
              state   <= FILL;
              m_valid <= 1'b0;
              m_data  <= '0;
              m_keep  <= '0;
              m_last  <= 1'b0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Valid/ready width converter. Packs RATIO consecutive narrow beats into one wide beat.
- Sits directly downstream of the single-stage pipeline register. Consumes its out_valid/out_data/out_ready stream and feeds wide consumers (e.g. 128-bit memory writer).
- Supports short packets via s_last: a partial wide beat is flushed with a lane-keep mask.

Parameters:
- IN_W, 32, narrow beat width in bits
- RATIO, 4, narrow beats per wide beat (power of 2, >=2)

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- s_valid  input  1  narrow beat valid
- s_data  input  IN_W  narrow beat data
- s_last  input  1  last beat of packet
- s_ready  output  1  narrow side ready
- m_valid  output  1  wide beat valid
- m_data  output  IN_W*RATIO  wide beat data
- m_keep  output  RATIO  per-lane valid mask
- m_last  output  1  wide beat contains packet end
- m_ready  input  1  wide side ready

Behaviour:
- Reset and clock: rstn is asynchronous, active-low; clk is the clock.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, lane count=0, state FILL. s_ready=1 once rstn is released.
- Handshake: a transfer occurs when valid&&ready on a side. m_data, m_keep and m_last are stable while m_valid&&!m_ready.
- State FILL:
  - s_ready=1 and m_valid=0.
  - An accepted beat writes s_data into lane cnt (bits cnt*IN_W +: IN_W), sets m_keep[cnt], and increments cnt.
  - If cnt==RATIO-1 or s_last=1 on the accepted beat: go to HOLD next cycle, m_valid=1, m_last=s_last, cnt=0.
- State HOLD:
  - m_valid=1 and s_ready=m_ready. This is a combinational pass-through of m_ready and gives full throughput.
  - m_ready=0: nothing changes and no input is accepted.
  - m_ready=1, s_valid=0: go to FILL; clear m_keep, m_data and m_last.
  - m_ready=1, s_valid=1: the wide beat drains. In the same cycle the new beat is written into lane 0 with m_keep=1 in lane 0 only, other lanes zeroed, cnt=1.
    - If that beat has s_last=1 (or RATIO reached), stay in HOLD with the new partial word and m_last=s_last.
    - Otherwise go to FILL.
- Latency: the wide beat is valid the cycle after the completing narrow beat is accepted.
- Unused lanes of a partial word read 0 and their m_keep bit is 0.
- cnt is $clog2(RATIO) bits and wraps to 0 on completion or s_last.
- Packets need not be aligned; each packet starts at lane 0.
- Reset mid-operation: the partial word is discarded and the reset values apply immediately (asynchronously).
- s_valid must not depend on s_ready. Once asserted, s_valid and s_data hold until accepted. The block does not check this.

Optional Feature:
- Macro: STREAM_UPSIZER_MSB_FIRST_EN
- Defined: the first narrow beat fills lane RATIO-1 and lanes fill downward; m_keep bits are set from MSB down.
- Not defined: the first beat fills lane 0 and lanes fill upward (LSB-first), as described above.
- Handshake, timing and last handling are identical in both builds.

Test Plan:
- Full word: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, s_last=0, m_ready=1 -> one beat m_data=0x44444444_33333333_22222222_11111111, m_keep=4'b1111, m_last=0, one cycle after the 4th accept.
- Short packet: beats 0xA, 0xB with s_last on 0xB -> m_data=0x0..0_0000000B_0000000A, m_keep=4'b0011, m_last=1.
- Backpressure:
  - Full word pending, m_ready=0 for 5 cycles -> s_ready=0, and m_data/m_keep are stable for all 5 cycles.
  - On release, the next beat 0x55 is accepted in the same cycle into lane 0.
- Streaming: 16 contiguous beats, m_ready=1 throughout -> 4 wide beats, s_ready never drops, no bubbles after the first.
- Single-beat packets back-to-back in HOLD with m_ready=1 -> each cycle emits m_keep=4'b0001, m_last=1, data 0x1, 0x2, 0x3 in order.
- Reset: after 2 beats accepted, assert rstn low -> m_valid=0, m_keep=0. The next packet 0x77 with s_last -> m_keep=4'b0001 (no stale lanes).
